// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: round-robin writeback arbiter and RAW/WAW hazard scoreboard for a 2**AW x XLEN regfile
module regfile_wb_sched #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid_i,
  input  logic [AW-1:0]     iss_rd_i,
  input  logic [AW-1:0]     iss_rs1_i,
  input  logic [AW-1:0]     iss_rs2_i,
  output logic              iss_stall_o,
  input  logic              alu_valid_i,
  input  logic [AW-1:0]     alu_rd_i,
  input  logic [XLEN-1:0]   alu_data_i,
  output logic              alu_ready_o,
  input  logic              lsu_valid_i,
  input  logic [AW-1:0]     lsu_rd_i,
  input  logic [XLEN-1:0]   lsu_data_i,
  output logic              lsu_ready_o,
  output logic              wreg_o,
  output logic [AW-1:0]     waddr_o,
  output logic [XLEN-1:0]   wrdata_o,
  output logic [2**AW-1:0]  busy_vec_o,
  output logic              err_stray_o
);
  localparam int NR = 2**AW;
  localparam logic [NR-1:0] ONE = NR'(1);
  logic [NR-1:0] busy_q, busy_d, clr, set;
  logic rr_q, rr_d, alu_g, lsu_g, acc, wreg_q, wreg_d, err_q, err_d;
  logic [AW-1:0] waddr_q, waddr_d, win_rd;
  logic [XLEN-1:0] wrdata_q, wrdata_d, win_data;
  always_comb begin
    iss_stall_o = iss_valid_i & (busy_q[iss_rs1_i] | busy_q[iss_rs2_i] | busy_q[iss_rd_i]);
    acc = iss_valid_i & ~iss_stall_o & (iss_rd_i != '0);
    // rr_q=0 favours the ALU when both producers compete
    alu_g = alu_valid_i & (~lsu_valid_i | ~rr_q);
    lsu_g = lsu_valid_i & ~alu_g;
    rr_d = (alu_valid_i & lsu_valid_i) ? ~rr_q : rr_q;
    win_rd = alu_g ? alu_rd_i : lsu_rd_i;
    win_data = alu_g ? alu_data_i : lsu_data_i;
    wreg_d = (alu_g | lsu_g) & (win_rd != '0);
    waddr_d = wreg_d ? win_rd : waddr_q;
    wrdata_d = wreg_d ? win_data : wrdata_q;
    err_d = err_q | (wreg_d & ~busy_q[win_rd]);
    clr = wreg_q ? ONE << waddr_q : '0;
    set = acc ? ONE << iss_rd_i : '0;
    busy_d = ((busy_q & ~clr) | set) & ~ONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      rr_q <= 1'b0;
      wreg_q <= 1'b0;
      waddr_q <= '0;
      wrdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      rr_q <= rr_d;
      wreg_q <= wreg_d;
      waddr_q <= waddr_d;
      wrdata_q <= wrdata_d;
      err_q <= err_d;
    end
  end
  assign alu_ready_o = alu_g;
  assign lsu_ready_o = lsu_g;
  assign wreg_o = wreg_q;
  assign waddr_o = waddr_q;
  assign wrdata_o = wrdata_q;
  assign busy_vec_o = busy_q;
  assign err_stray_o = err_q;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: directed and random stimulus checked against a cycle-level reference model
module tb_regfile_wb_sched;
  localparam int XLEN = 32, AW = 5, NR = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  logic iss_valid, alu_valid, lsu_valid;
  logic [AW-1:0] iss_rd, iss_rs1, iss_rs2, alu_rd, lsu_rd;
  logic [XLEN-1:0] alu_data, lsu_data;
  logic iss_stall_o, alu_ready_o, lsu_ready_o, wreg_o, err_stray_o;
  logic [AW-1:0] waddr_o;
  logic [XLEN-1:0] wrdata_o;
  logic [NR-1:0] busy_vec_o;
  logic [XLEN-1:0] dut_rf [NR] = '{default: '0};
  bit m_busy [NR];
  bit m_rr, m_wreg, m_err, s_ar, s_lr;
  logic [AW-1:0] m_waddr;
  logic [XLEN-1:0] m_wrdata;
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  regfile_wb_sched #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .iss_rs1_i(iss_rs1), .iss_rs2_i(iss_rs2),
    .iss_stall_o(iss_stall_o),
    .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_data_i(alu_data), .alu_ready_o(alu_ready_o),
    .lsu_valid_i(lsu_valid), .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data), .lsu_ready_o(lsu_ready_o),
    .wreg_o(wreg_o), .waddr_o(waddr_o), .wrdata_o(wrdata_o),
    .busy_vec_o(busy_vec_o), .err_stray_o(err_stray_o)
  );

  // architectural register file fed by the scheduler's write port
  always @(posedge clk) if (wreg_o && waddr_o != '0) dut_rf[waddr_o] <= wrdata_o;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] mbusy();
    logic [NR-1:0] r;
    for (int i = 0; i < NR; i++) r[i] = m_busy[i];
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
    m_rr = 1'b0; m_wreg = 1'b0; m_err = 1'b0; m_waddr = '0; m_wrdata = '0;
  endtask

  task automatic set_iss(input bit v, input int rd, input int rs1, input int rs2);
    iss_valid = v; iss_rd = AW'(rd); iss_rs1 = AW'(rs1); iss_rs2 = AW'(rs2);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wreg"}, wreg_o, 0);
    chk({tag, "_waddr"}, waddr_o, 0);
    chk({tag, "_wrdata"}, wrdata_o, 0);
    chk({tag, "_busy"}, busy_vec_o, 0);
    chk({tag, "_err"}, err_stray_o, 0);
  endtask

  // one clock: check combinational outputs, advance model at the edge, check registered outputs
  task automatic step();
    bit ag, lg, st, both;
    logic [AW-1:0] rd;
    logic [XLEN-1:0] d;
    #1;
    both = alu_valid && lsu_valid;
    ag = both ? !m_rr : alu_valid;
    lg = both ? m_rr : lsu_valid;
    st = iss_valid && (m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_rd]);
    chk("stall", iss_stall_o, st);
    chk("alu_ready", alu_ready_o, ag);
    chk("lsu_ready", lsu_ready_o, lg);
    s_ar = alu_ready_o; s_lr = lsu_ready_o;
    @(posedge clk);
    rd = ag ? alu_rd : lsu_rd;
    d = ag ? alu_data : lsu_data;
    if ((ag || lg) && rd != '0 && !m_busy[rd]) m_err = 1'b1;
    if (m_wreg) m_busy[m_waddr] = 1'b0;
    if (iss_valid && !st && iss_rd != '0) m_busy[iss_rd] = 1'b1;
    m_wreg = (ag || lg) && rd != '0;
    if (m_wreg) begin m_waddr = rd; m_wrdata = d; end
    if (both) m_rr = !m_rr;
    #1;
    chk("wreg", wreg_o, m_wreg);
    chk("waddr", waddr_o, m_waddr);
    chk("wrdata", wrdata_o, m_wrdata);
    chk("busy_vec", busy_vec_o, mbusy());
    chk("err_stray", err_stray_o, m_err);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk_zero(tag);
    m_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int ai, li, n, wcnt;
    int gseq[$];
    logic [XLEN-1:0] ad, ld, d6;
    set_iss(0, 0, 0, 0);
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
    m_reset();
    #2 chk_zero("rst0");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // RAW hazard on x5 resolved by an ALU write
    set_iss(1, 5, 0, 0); step();
    set_iss(1, 0, 5, 0);
    #1 chk("t2_stall_raw", iss_stall_o, 1);
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; step();
    chk("t2_wreg", wreg_o, 1);
    chk("t2_stall_wb", iss_stall_o, 1);
    alu_valid = 0; step();
    chk("t2_stall_drop", iss_stall_o, 0);
    chk("t2_rf", dut_rf[5], 32'hDEADBEEF);
    set_iss(0, 0, 0, 0); step();

    // both producers contend: grants alternate, one write per cycle
    for (int i = 0; i < 8; i++) begin set_iss(1, i < 4 ? i + 1 : i + 5, 0, 0); step(); end
    set_iss(0, 0, 0, 0);
    ai = 0; li = 0; n = 0; wcnt = 0; ad = $urandom; ld = $urandom;
    while ((ai < 4 || li < 4) && n < 12) begin
      alu_valid = ai < 4; alu_rd = AW'(ai + 1); alu_data = ad;
      lsu_valid = li < 4; lsu_rd = AW'(li + 9); lsu_data = ld;
      step(); n++;
      if (wreg_o) wcnt++;
      if (s_ar) begin gseq.push_back(0); ai++; ad = $urandom; end
      if (s_lr) begin gseq.push_back(1); li++; ld = $urandom; end
    end
    alu_valid = 0; lsu_valid = 0;
    chk("t3_cycles", n, 8);
    chk("t3_writes", wcnt, 8);
    for (int i = 0; i < 8; i++) chk("t3_grant", gseq.size() > i ? gseq[i] : -1, i % 2);
    step();
    chk("t3_busy_clear", busy_vec_o, 0);

    // result for x0 is consumed without a write
    alu_valid = 1; alu_rd = 0; alu_data = 32'h1234; step();
    chk("t4_ready", s_ar, 1);
    chk("t4_wreg", wreg_o, 0);
    chk("t4_busy", busy_vec_o, 0);
    alu_valid = 0;

    // stray LSU write to x6
    d6 = $urandom;
    lsu_valid = 1; lsu_rd = 6; lsu_data = d6; step();
    chk("t5_wreg", wreg_o, 1);
    chk("t5_err", err_stray_o, 1);
    lsu_valid = 0; step();
    chk("t5_rf", dut_rf[6], d6);

    // WAW on x8, then set/clear collision on x13
    set_iss(1, 8, 0, 0); step();
    #1 chk("t6_stall_waw", iss_stall_o, 1);
    lsu_valid = 1; lsu_rd = 8; lsu_data = $urandom; step();
    lsu_valid = 0; step();
    step();
    chk("t6_busy8", busy_vec_o[8], 1);
    set_iss(0, 0, 0, 0);
    lsu_valid = 1; lsu_rd = 13; lsu_data = $urandom; step();
    lsu_valid = 0; set_iss(1, 13, 0, 0); step();
    chk("t6_set_wins", busy_vec_o[13], 1);
    set_iss(0, 0, 0, 0); step();
    chk("t6_err_sticky", err_stray_o, 1);

    // random traffic; producers hold rd/data until accepted
    alu_valid = 0; lsu_valid = 0;
    for (int c = 0; c < 400; c++) begin
      if (!alu_valid || s_ar) begin
        alu_valid = 1'($urandom_range(0, 1)); alu_rd = AW'($urandom_range(0, 15)); alu_data = $urandom;
      end
      if (!lsu_valid || s_lr) begin
        lsu_valid = 1'($urandom_range(0, 1)); lsu_rd = AW'($urandom_range(0, 15)); lsu_data = $urandom;
      end
      set_iss(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      step();
    end

    // asynchronous reset in the middle of a writeback with x3,x7 pending
    set_iss(0, 0, 0, 0); alu_valid = 0; lsu_valid = 0;
    do_reset("t1_pre");
    set_iss(1, 3, 0, 0); step();
    set_iss(1, 7, 0, 0); step();
    chk("t1_busy37", busy_vec_o, 32'h88);
    set_iss(0, 0, 0, 0);
    alu_valid = 1; alu_rd = 3; alu_data = $urandom; step();
    chk("t1_wreg_before", wreg_o, 1);
    #2 do_reset("t1_mid");
    alu_valid = 0;
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
